// File: rtl/grad_descent_ctrl.sv
// Iterative gradient-descent controller: issues evaluation requests, captures the
// returned step and value, applies a saturating update and reports why it stopped.
module grad_descent_ctrl #(
  parameter int unsigned MAX_ITER = 256,
  parameter logic [31:0] TOL      = 32'h0000_0001,
  parameter int unsigned TIMEOUT  = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] x_init,
  output logic        start_func,
  output logic [31:0] x_eval,
  input  logic        func_done,
  input  logic [31:0] x_diff_in,
  input  logic [63:0] value_in,
  input  logic        overflow_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] x_final,
  output logic [63:0] value_final,
  output logic [15:0] iter_count,
  output logic [1:0]  status
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_LOW, WAIT_HIGH, UPDATE, FINISH} state_t;
  typedef enum logic [1:0] {ST_CONV = 2'd0, ST_MAXIT = 2'd1, ST_OVF = 2'd2, ST_TMO = 2'd3} status_t;

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [15:0]   ITER_LIM = 16'(MAX_ITER);

  state_t        state;
  logic [TW-1:0] tmo_cnt;
  logic [31:0]   x_diff_q;
  logic          ovf_q;

  logic [32:0] diff33;
  logic [31:0] x_sat;
  logic [31:0] diff_abs;
  logic [15:0] iter_next;

  // NOTE: every signal assigned in always_comb gets a default first, so no latch can be inferred.
  always_comb begin
    diff33    = {x_eval[31], x_eval} - {x_diff_q[31], x_diff_q};
    x_sat     = diff33[31:0];
    diff_abs  = x_diff_q;
    iter_next = iter_count + 16'd1;
    // Sign bits disagreeing means the 33-bit result no longer fits in 32 bits.
    if (diff33[32:31] == 2'b01)      x_sat = 32'h7FFF_FFFF;
    else if (diff33[32:31] == 2'b10) x_sat = 32'h8000_0000;
    if (x_diff_q == 32'h8000_0000)   diff_abs = 32'h7FFF_FFFF;
    else if (x_diff_q[31])           diff_abs = -x_diff_q;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      tmo_cnt     <= '0;
      x_diff_q    <= '0;
      ovf_q       <= 1'b0;
      start_func  <= 1'b0;
      x_eval      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      x_final     <= '0;
      value_final <= '0;
      iter_count  <= '0;
      status      <= ST_CONV;
    end else begin
      start_func <= 1'b0;
      done       <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            x_eval     <= x_init;
            iter_count <= '0;
            status     <= ST_CONV;
            busy       <= 1'b1;
            start_func <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          tmo_cnt <= '0;
          state   <= WAIT_LOW;
        end
        WAIT_LOW, WAIT_HIGH: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          if (state == WAIT_HIGH && func_done) begin
            x_diff_q    <= x_diff_in;
            ovf_q       <= overflow_in;
            value_final <= value_in;
            state       <= UPDATE;
          end else if (tmo_cnt == TMO_LAST) begin
            status  <= ST_TMO;
            x_final <= x_eval;
            done    <= 1'b1;
            state   <= FINISH;
          end else if (state == WAIT_LOW && !func_done) begin
            state <= WAIT_HIGH;
          end
        end
        UPDATE: begin
          iter_count <= iter_next;
          if (ovf_q) begin
            status  <= ST_OVF;
            x_final <= x_eval;
            done    <= 1'b1;
            state   <= FINISH;
          end else begin
            x_eval <= x_sat;
            if (diff_abs <= TOL) begin
              status  <= ST_CONV;
              x_final <= x_sat;
              done    <= 1'b1;
              state   <= FINISH;
            end else if (iter_next == ITER_LIM) begin
              status  <= ST_MAXIT;
              x_final <= x_sat;
              done    <= 1'b1;
              state   <= FINISH;
            end else begin
              start_func <= 1'b1;
              state      <= ISSUE;
            end
          end
        end
        FINISH: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_grad_descent_ctrl.sv
// Directed bench for grad_descent_ctrl: two instances (long / short iteration limit)
// share one behavioural evaluator stub selected by sel.
module tb_grad_descent_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_a = 1'b0, start_b = 1'b0;
  logic [31:0] x_init = '0;
  logic        func_done;
  logic [31:0] x_diff_in;
  logic [63:0] value_in;
  logic        overflow_in;

  logic        sf_a, sf_b, busy_a, busy_b, done_a, done_b;
  logic [31:0] xe_a, xe_b, xf_a, xf_b;
  logic [63:0] vf_a, vf_b;
  logic [15:0] ic_a, ic_b;
  logic [1:0]  st_a, st_b;

  int sel  = 0;
  int mode = 0;   // 0 halve, 1 const 0x100, 2 const + overflow on 3rd, 3 done stuck high
  int total = 0, bad = 0;
  int pulses = 0, dones = 0;

  always #5 clk = ~clk;

  grad_descent_ctrl #(.MAX_ITER(256), .TOL(32'h1), .TIMEOUT(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .x_init(x_init),
    .start_func(sf_a), .x_eval(xe_a), .func_done(func_done), .x_diff_in(x_diff_in),
    .value_in(value_in), .overflow_in(overflow_in), .busy(busy_a), .done(done_a),
    .x_final(xf_a), .value_final(vf_a), .iter_count(ic_a), .status(st_a));

  grad_descent_ctrl #(.MAX_ITER(4), .TOL(32'h1), .TIMEOUT(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .x_init(x_init),
    .start_func(sf_b), .x_eval(xe_b), .func_done(func_done), .x_diff_in(x_diff_in),
    .value_in(value_in), .overflow_in(overflow_in), .busy(busy_b), .done(done_b),
    .x_final(xf_b), .value_final(vf_b), .iter_count(ic_b), .status(st_b));

  wire        sf_s   = sel ? sf_b   : sf_a;
  wire        busy_s = sel ? busy_b : busy_a;
  wire        done_s = sel ? done_b : done_a;
  wire [31:0] xe_s   = sel ? xe_b   : xe_a;
  wire [31:0] xf_s   = sel ? xf_b   : xf_a;
  wire [63:0] vf_s   = sel ? vf_b   : vf_a;
  wire [15:0] ic_s   = sel ? ic_b   : ic_a;
  wire [1:0]  st_s   = sel ? st_b   : st_a;

  // Evaluator stub: answers 3 edges after seeing start_func with a one-cycle func_done.
  logic signed [31:0] xe_lat;
  int pend, resp_n;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      func_done <= 1'b0; x_diff_in <= '0; value_in <= '0; overflow_in <= 1'b0;
      pend <= 0; resp_n <= 0; xe_lat <= '0;
    end else begin
      if (!busy_s) resp_n <= 0;
      if (mode == 3) func_done <= 1'b1;
      else if (sf_s) begin
        pend <= 3; xe_lat <= xe_s; func_done <= 1'b0;
      end else if (pend != 0) begin
        pend <= pend - 1;
        if (pend == 1) begin
          func_done   <= 1'b1;
          x_diff_in   <= (mode == 0) ? (xe_lat >>> 1) : 32'h100;
          value_in    <= {32'h0000_00A5, xe_lat};
          overflow_in <= (mode == 2) && (resp_n == 2);
          resp_n      <= resp_n + 1;
        end
      end else func_done <= 1'b0;
    end
  end

  always @(posedge clk) begin
    if (sf_s) pulses <= pulses + 1;
    if (done_s) dones <= dones + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run(input int s, input int m, input logic [31:0] x0, input int budget,
                     output int cyc, output bit ok);
    sel = s; mode = m; x_init = x0;
    @(negedge clk);
    if (s != 0) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0;
    check("busy_after_start", busy_s, 1);
    cyc = 0; ok = 0;
    while (cyc < budget && !ok) begin
      @(posedge clk); #1;
      cyc++;
      if (done_s) ok = 1;
    end
  endtask

  task automatic after_done();
    @(posedge clk); #1;
    check("done_one_cycle", done_s, 0);
    check("busy_falls", busy_s, 0);
  endtask

  int cyc, p0;
  bit ok;

  initial begin
    #12;
    check("rst_x_eval", xe_a, 0);
    check("rst_flags", {sf_a, busy_a, done_a}, 0);
    check("rst_outputs", {xf_a, ic_a, st_a}, 0);
    check("rst_value", vf_a, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Convergence: x_diff = x/2 from 0x500 reaches |x_diff|<=1 after 10 steps
    run(0, 0, 32'h500, 200, cyc, ok);
    check("conv_done", ok, 1);
    check("conv_status", st_s, 0);
    check("conv_iter", ic_s, 10);
    check("conv_x", xf_s, 32'h2);
    check("conv_value", vf_s, 64'h0000_00A5_0000_0003);
    after_done();

    // Iteration limit: 4 steps of 0x100 from 0x1000
    p0 = pulses;
    run(1, 1, 32'h1000, 100, cyc, ok);
    check("maxit_done", ok, 1);
    check("maxit_status", st_s, 1);
    check("maxit_iter", ic_s, 4);
    check("maxit_x", xf_s, 32'h0C00);
    check("maxit_value", vf_s, 64'h0000_00A5_0000_0D00);
    check("maxit_pulses", pulses - p0, 4);
    after_done();

    // Saturation at the negative rail
    run(1, 1, 32'h8000_0010, 100, cyc, ok);
    check("sat_done", ok, 1);
    check("sat_status", st_s, 1);
    check("sat_x", xf_s, 32'h8000_0000);
    after_done();

    // Overflow on 3rd response: only two updates applied
    run(0, 2, 32'h1000, 100, cyc, ok);
    check("ovf_done", ok, 1);
    check("ovf_status", st_s, 2);
    check("ovf_iter", ic_s, 3);
    check("ovf_x", xf_s, 32'h0E00);
    after_done();

    // Stale done held high: never accepted, times out
    run(0, 3, 32'h1000, 40, cyc, ok);
    check("tmo_done", ok, 1);
    check("tmo_within_20", cyc <= 20, 1);
    check("tmo_status", st_s, 3);
    check("tmo_iter", ic_s, 0);
    check("tmo_x", xf_s, 32'h1000);
    after_done();
    mode = 0;
    repeat (3) @(negedge clk);

    // Reset during WAIT_HIGH of the first iteration
    sel = 0; x_init = 32'h500;
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    cyc = 0;
    while (cyc < 20 && !sf_a) begin @(posedge clk); #1; cyc++; end
    check("mid_issue_seen", sf_a, 1);
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check("mid_rst_x_eval", xe_a, 0);
    check("mid_rst_outputs", {xf_a, ic_a, st_a}, 0);
    check("mid_rst_value", vf_a, 0);
    check("mid_rst_flags", {sf_a, busy_a, done_a}, 0);
    p0 = pulses + dones;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("no_pulse_around_rst", pulses + dones, p0);

    run(0, 0, 32'h500, 200, cyc, ok);
    check("rerun_done", ok, 1);
    check("rerun_status", st_s, 0);
    check("rerun_iter", ic_s, 10);
    check("rerun_x", xf_s, 32'h2);
    after_done();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
